// File: rtl/axi_wdata_router.sv
// axi_wdata_router
//   Write-data (W) channel router for one target port of the AXI node.
//   Routing entries {err, dest, len} from the AW-side decoder are queued in
//   order. The head entry steers the current W burst to exactly one
//   initiator port, or sinks it locally when the entry is a decode error.
//   Bursts end on an internal beat counter compared with the recorded
//   awlen; the incoming wlast is never used to terminate a burst.
//
// Parameters
//   N_INIT_PORT : number of initiator ports (>= 1)
//   FIFO_DEPTH  : routing-entry queue depth (power of two, >= 2)
//   LEN_WIDTH   : width of the awlen field
//
// Ports
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   test_en_i    : test mode for queue clock gating, no functional effect
//   dest_i       : one-hot destination of the pushed entry
//   err_i        : pushed entry is a decode error
//   len_i        : awlen (beats-1) of the pushed entry
//   push_i       : push entry, honoured only while grant_o is high
//   grant_o      : queue not full (registered occupancy)
//   busy_o       : queue non-empty
//   wvalid_i     : upstream W valid
//   wlast_i      : upstream W last (only checked, never trusted)
//   wready_o     : upstream W ready
//   wvalid_o     : per-initiator W valid
//   wready_i     : per-initiator W ready
//   wlast_o      : counter-generated last, shared by all initiators
//   err_done_o   : one-cycle pulse on the last beat of a sunk error burst
//   wlast_err_o  : sticky flag, upstream wlast disagreed with the counter
//
// Handshake: a beat transfers in a cycle where wvalid_i and wready_o are both
// high. Downstream, a beat transfers to the selected initiator when its
// wvalid_o bit and wready_i bit are both high; wready_o mirrors the selected
// initiator's wready_i, so both sides transfer in the same cycle.
//
// Configuration
//   `define AXI_WDATA_ROUTER_LAST_CHECK_EN enables the wlast_i vs. counter
//   comparison driving wlast_err_o. Without it wlast_err_o is tied low.

module axi_wdata_router #(
    parameter int unsigned N_INIT_PORT = 4,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned LEN_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   test_en_i,
    input  logic [N_INIT_PORT-1:0] dest_i,
    input  logic                   err_i,
    input  logic [LEN_WIDTH-1:0]   len_i,
    input  logic                   push_i,
    output logic                   grant_o,
    input  logic                   wvalid_i,
    input  logic                   wlast_i,
    output logic                   wready_o,
    output logic [N_INIT_PORT-1:0] wvalid_o,
    input  logic [N_INIT_PORT-1:0] wready_i,
    output logic                   wlast_o,
    output logic                   err_done_o,
    output logic                   busy_o,
    output logic                   wlast_err_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    // Entry storage, split per field.
    logic                   mem_err  [FIFO_DEPTH];
    logic [N_INIT_PORT-1:0] mem_dest [FIFO_DEPTH];
    logic [LEN_WIDTH-1:0]   mem_len  [FIFO_DEPTH];

    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     fill;
    logic [LEN_WIDTH-1:0] cnt;

    logic                   empty;
    logic                   push_ok;
    logic                   head_err;
    logic [N_INIT_PORT-1:0] head_dest;
    logic [LEN_WIDTH-1:0]   head_len;
    logic                   term;
    logic                   beat;
    logic                   pop;

    // Test mode has no functional effect on the queue.
    logic unused_test_en;
    assign unused_test_en = test_en_i;

    assign empty   = (fill == '0);
    assign grant_o = (fill != CNT_W'(FIFO_DEPTH));
    assign busy_o  = !empty;
    assign push_ok = push_i & grant_o;

    assign head_err  = mem_err[rd_ptr];
    assign head_dest = mem_dest[rd_ptr];
    assign head_len  = mem_len[rd_ptr];
    assign term      = (cnt == head_len);

    // Mode decode from the head entry: IDLE (empty), ROUTE, DRAIN (error).
    always_comb begin
        wready_o   = 1'b0;
        wvalid_o   = '0;
        wlast_o    = 1'b0;
        err_done_o = 1'b0;
        if (!empty) begin
            if (head_err) begin
                wready_o   = 1'b1;
                err_done_o = wvalid_i & term;
            end else begin
                wvalid_o = head_dest & {N_INIT_PORT{wvalid_i}};
                wready_o = |(wready_i & head_dest);
                wlast_o  = term;
            end
        end
    end

    assign beat = wvalid_i & wready_o;
    assign pop  = beat & term;

    // An all-zero destination has nowhere to go, so it is stored as an error.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_err[wr_ptr]  <= err_i | (dest_i == '0);
            mem_dest[wr_ptr] <= dest_i;
            mem_len[wr_ptr]  <= len_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   fill <= fill + CNT_W'(1);
                2'b01:   fill <= fill - CNT_W'(1);
                default: fill <= fill;
            endcase
            // term fires at cnt == len, so cnt never needs to wrap.
            if (beat) begin
                cnt <= term ? '0 : cnt + LEN_WIDTH'(1);
            end
        end
    end

`ifdef AXI_WDATA_ROUTER_LAST_CHECK_EN
    // Sticky: routing keeps following cnt, this only reports disagreement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wlast_err_o <= 1'b0;
        end else if (beat && (wlast_i != term)) begin
            wlast_err_o <= 1'b1;
        end
    end
`else
    logic unused_wlast;
    assign unused_wlast = wlast_i;
    assign wlast_err_o  = 1'b0;
`endif

    // A routed entry may target at most one initiator port.
    a_dest_onehot: assert property (
        @(posedge clk) disable iff (!rst_n)
        (push_ok && !err_i) |-> $onehot0(dest_i)
    );

endmodule

// File: tb/tb_axi_wdata_router.sv
// Directed bench for axi_wdata_router (default parameters: 4 ports, depth 8).
// Inputs are driven just after the falling edge; outputs are checked 1 ns
// later, well away from the rising edge that commits the cycle.

module tb_axi_wdata_router;

    logic       clk;
    logic       rst_n;
    logic       test_en_i;
    logic [3:0] dest_i;
    logic       err_i;
    logic [7:0] len_i;
    logic       push_i;
    logic       grant_o;
    logic       wvalid_i;
    logic       wlast_i;
    logic       wready_o;
    logic [3:0] wvalid_o;
    logic [3:0] wready_i;
    logic       wlast_o;
    logic       err_done_o;
    logic       busy_o;
    logic       wlast_err_o;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_q[$];
    logic [3:0] exp_d;
    logic       exp_le;

    axi_wdata_router #(
        .N_INIT_PORT(4),
        .FIFO_DEPTH (8),
        .LEN_WIDTH  (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .test_en_i  (test_en_i),
        .dest_i     (dest_i),
        .err_i      (err_i),
        .len_i      (len_i),
        .push_i     (push_i),
        .grant_o    (grant_o),
        .wvalid_i   (wvalid_i),
        .wlast_i    (wlast_i),
        .wready_o   (wready_o),
        .wvalid_o   (wvalid_o),
        .wready_i   (wready_i),
        .wlast_o    (wlast_o),
        .err_done_o (err_done_o),
        .busy_o     (busy_o),
        .wlast_err_o(wlast_err_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge (previous rising edge has committed).
    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic p, input logic e, input logic [3:0] d,
                         input logic [7:0] l, input logic v, input logic lst);
        push_i   = p;
        err_i    = e;
        dest_i   = d;
        len_i    = l;
        wvalid_i = v;
        wlast_i  = lst;
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},   busy_o,     1'b0);
        check({tag, "_grant"},  grant_o,    1'b1);
        check({tag, "_wready"}, wready_o,   1'b0);
        check({tag, "_wvalid"}, wvalid_o,   4'b0000);
        check({tag, "_wlast"},  wlast_o,    1'b0);
        check({tag, "_errdn"},  err_done_o, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        test_en_i = 1'b0;
        wready_i  = 4'hF;
        drive(1'b0, 1'b0, 4'b0000, 8'd0, 1'b0, 1'b0);

        // ---- reset state
        step();
        check_idle("rst");
        check("rst_wlast_err", wlast_err_o, 1'b0);
        rst_n = 1'b1;
        step();

        // ---- routed burst, dest=0100 len=3, pushed with wvalid already high
        drive(1'b1, 1'b0, 4'b0100, 8'd3, 1'b1, 1'b0);
        check("t1_push_stall_wready", wready_o, 1'b0);
        check("t1_push_stall_wvalid", wvalid_o, 4'b0000);
        step();
        // selected port not ready: upstream stalls, wvalid_o still presented
        wready_i = 4'b1011;
        drive(1'b0, 1'b0, 4'b0000, 8'd0, 1'b1, 1'b0);
        check("t1_busy", busy_o, 1'b1);
        check("t1_blocked_wready", wready_o, 1'b0);
        check("t1_blocked_wvalid", wvalid_o, 4'b0100);
        step();
        wready_i = 4'hF;
        for (int b = 1; b <= 4; b++) begin
            drive(1'b0, 1'b0, 4'b0000, 8'd0, 1'b1, (b == 4));
            check($sformatf("t1_beat%0d_wvalid", b), wvalid_o, 4'b0100);
            check($sformatf("t1_beat%0d_wready", b), wready_o, 1'b1);
            check($sformatf("t1_beat%0d_wlast", b),  wlast_o,  (b == 4));
            step();
        end
        drive(1'b0, 1'b0, 4'b0000, 8'd0, 1'b0, 1'b0);
        check_idle("t1_after");

        // ---- error burst len=1, sunk locally
        drive(1'b1, 1'b1, 4'b0010, 8'd1, 1'b0, 1'b0);
        step();
        wready_i = 4'b0000;
        drive(1'b0, 1'b0, 4'b0000, 8'd0, 1'b1, 1'b0);
        check("t2_beat1_wready", wready_o, 1'b1);
        check("t2_beat1_wvalid", wvalid_o, 4'b0000);
        check("t2_beat1_errdn",  err_done_o, 1'b0);
        check("t2_beat1_wlast",  wlast_o, 1'b0);
        step();
        drive(1'b0, 1'b0, 4'b0000, 8'd0, 1'b1, 1'b1);
        check("t2_beat2_wready", wready_o, 1'b1);
        check("t2_beat2_wvalid", wvalid_o, 4'b0000);
        check("t2_beat2_errdn",  err_done_o, 1'b1);
        step();
        drive(1'b0, 1'b0, 4'b0000, 8'd0, 1'b0, 1'b0);
        check_idle("t2_after");

        // ---- dest=0 without err behaves as an error entry
        drive(1'b1, 1'b0, 4'b0000, 8'd0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 4'b0000, 8'd0, 1'b1, 1'b1);
        check("t2b_wready", wready_o, 1'b1);
        check("t2b_wvalid", wvalid_o, 4'b0000);
        check("t2b_errdn",  err_done_o, 1'b1);
        step();
        drive(1'b0, 1'b0, 4'b0000, 8'd0, 1'b0, 1'b0);
        check_idle("t2b_after");
        wready_i = 4'hF;

        // ---- fill queue with 8 single-beat entries, 9th push ignored
        for (int i = 0; i < 8; i++) begin
            exp_d = 4'b0001 << (i % 4);
            exp_q.push_back(exp_d);
            drive(1'b1, 1'b0, exp_d, 8'd0, 1'b0, 1'b0);
            check($sformatf("t3_push%0d_grant", i), grant_o, 1'b1);
            step();
        end
        drive(1'b1, 1'b0, 4'b1000, 8'd0, 1'b0, 1'b0);
        check("t3_full_grant", grant_o, 1'b0);
        check("t3_full_busy",  busy_o,  1'b1);
        step();
        for (int i = 0; i < 8; i++) begin
            exp_d = exp_q.pop_front();
            drive(1'b0, 1'b0, 4'b0000, 8'd0, 1'b1, 1'b1);
            check($sformatf("t3_drain%0d_wvalid", i), wvalid_o, exp_d);
            check($sformatf("t3_drain%0d_wlast", i),  wlast_o,  1'b1);
            // occupancy is registered: still full during the first pop
            check($sformatf("t3_drain%0d_grant", i),  grant_o,  (i != 0));
            step();
        end
        drive(1'b0, 1'b0, 4'b0000, 8'd0, 1'b0, 1'b0);
        check_idle("t3_after");

        // ---- back-to-back single-beat bursts, wvalid held high
        drive(1'b1, 1'b0, 4'b0001, 8'd0, 1'b1, 1'b1);
        check("t4_c0_wvalid", wvalid_o, 4'b0000);
        step();
        drive(1'b1, 1'b0, 4'b1000, 8'd0, 1'b1, 1'b1);
        check("t4_c1_wvalid", wvalid_o, 4'b0001);
        check("t4_c1_wlast",  wlast_o,  1'b1);
        step();
        drive(1'b0, 1'b0, 4'b0000, 8'd0, 1'b1, 1'b1);
        check("t4_c2_wvalid", wvalid_o, 4'b1000);
        check("t4_c2_wlast",  wlast_o,  1'b1);
        step();
        drive(1'b0, 1'b0, 4'b0000, 8'd0, 1'b1, 1'b0);
        check_idle("t4_after");
        drive(1'b0, 1'b0, 4'b0000, 8'd0, 1'b0, 1'b0);

        // ---- len=2 burst with early wlast_i on beat 2
`ifdef AXI_WDATA_ROUTER_LAST_CHECK_EN
        exp_le = 1'b1;
`else
        exp_le = 1'b0;
`endif
        drive(1'b1, 1'b0, 4'b0010, 8'd2, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 4'b0000, 8'd0, 1'b1, 1'b0);
        check("t5_beat1_wlast", wlast_o, 1'b0);
        step();
        drive(1'b0, 1'b0, 4'b0000, 8'd0, 1'b1, 1'b1);
        check("t5_beat2_wlast", wlast_o, 1'b0);
        check("t5_beat2_lerr",  wlast_err_o, 1'b0);
        step();
        drive(1'b0, 1'b0, 4'b0000, 8'd0, 1'b1, 1'b1);
        check("t5_beat3_wvalid", wvalid_o, 4'b0010);
        check("t5_beat3_wlast",  wlast_o, 1'b1);
        check("t5_beat3_lerr",   wlast_err_o, exp_le);
        step();
        drive(1'b0, 1'b0, 4'b0000, 8'd0, 1'b0, 1'b0);
        check_idle("t5_after");
        check("t5_after_lerr", wlast_err_o, exp_le);

        // ---- reset mid-burst of len=7
        drive(1'b1, 1'b0, 4'b0001, 8'd7, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 4'b0000, 8'd0, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b0, 4'b0000, 8'd0, 1'b1, 1'b0);
        check("t6_beat2_wvalid", wvalid_o, 4'b0001);
        step();
        rst_n = 1'b0;
        #1;
        check_idle("t6_rst");
        check("t6_rst_lerr", wlast_err_o, 1'b0);
        step();
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 4'b1000, 8'd1, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 4'b0000, 8'd0, 1'b1, 1'b0);
        check("t6_new_beat1_wvalid", wvalid_o, 4'b1000);
        check("t6_new_beat1_wlast",  wlast_o, 1'b0);
        step();
        drive(1'b0, 1'b0, 4'b0000, 8'd0, 1'b1, 1'b1);
        check("t6_new_beat2_wlast",  wlast_o, 1'b1);
        step();
        drive(1'b0, 1'b0, 4'b0000, 8'd0, 1'b0, 1'b0);
        check_idle("t6_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
